ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter that shares one synchronous RAM port (byte write enables, one-cycle read latency) between the CPU memory stage (port 0) and an external loader/debug master (port 1). It arbitrates per cycle, supports locked sequences that hold ownership across accesses, returns read data one cycle after acceptance, and guarantees port 1 cannot starve. It sits between `memory`/loader and the `ram` data port.

## Interface
- ADDR_WIDTH, 9, word address width
- DATA_WIDTH, 32, data width
- WE_WIDTH, 4, byte enables (DATA_WIDTH/8)
- STARVE_LIMIT, 15, port-1 wait cycles before forced grant (fixed-priority build only)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req{0,1}_valid  in  1  access request
- req{0,1}_lock  in  1  keep ownership after this access
- req{0,1}_we  in  WE_WIDTH  byte write enables; all zero = read
- req{0,1}_addr  in  ADDR_WIDTH  word address
- req{0,1}_wdata  in  DATA_WIDTH  write data
- req{0,1}_ready  out  1  request accepted this cycle
- req{0,1}_rvalid  out  1  read data valid
- req{0,1}_rdata  out  DATA_WIDTH  read data (ram_rdata fan-out)
- ram_we  out  WE_WIDTH  RAM byte write enables
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid cycle after address

## Operation
- Transfer on reqN_valid & reqN_ready. At most one ready per cycle. ready is combinational from valid and registered state.
- States: IDLE, OWN0, OWN1.
- IDLE: if exactly one valid, grant it. If both valid, the tie-break rule (Configuration) decides.
- OWNk: only port k eligible; the other port's ready=0 even if k is idle.
- Transitions: IDLE -> OWNk on accepted k transfer with reqk_lock=1. OWNk -> IDLE on accepted k transfer with lock=0, or any cycle with reqk_valid=0 and reqk_lock=0. Otherwise remain.
- Granted port drives ram_we/addr/wdata combinationally. With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Read (we all zero) accepted in cycle N: reqN_rvalid=1 in cycle N+1 only. Writes never raise rvalid.
- Starve counter (port 1): increments, saturating at STARVE_LIMIT, each cycle req1_valid & !req1_ready. Clears on port-1 accept or on reset.
- Reset (asserted, any time, including mid-lock): state IDLE, rr pointer=1, starve count 0, rvalid 0. While reset is low, all ready=0 and ram_we=0. In-flight reads are dropped.

## Timing
- Accept-to-RAM latency: 0 cycles. Read-data latency: 1 cycle. Throughput: one access per cycle, back-to-back with no bubbles.
- Handover: a release in cycle N lets the other port be granted no earlier than N+1.
- rdata is never registered. The requester samples rdata only when rvalid=1.

## Configuration
- ARB_ROUND_ROBIN_EN defined: IDLE ties go to the port not granted most recently. The rr pointer updates on every accepted transfer and resets to 1, so port 0 wins the first tie. The starve counter is not instantiated.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, with port 0 winning ties. Exception: when the starve count equals STARVE_LIMIT, port 1 wins the tie.
- The lock/OWNk behaviour is identical in both builds.

## Structure
- Shared package `arb_pkg`: state encoding localparams (IDLE, OWN0, OWN1), port index constants, default STARVE_LIMIT.
- One sub-module, `starve_counter`: saturating counter with inc, clr and limit-reached output. It is compiled only when ARB_ROUND_ROBIN_EN is undefined.

## Test plan
- Reset release, req0 read addr 0x010: ready0 in the same cycle, ram_addr=0x010, rvalid0=1 the next cycle with RAM content 0xDEADBEEF.
- Both valid from idle, no locks: fixed build grants 0 every cycle; RR build alternates 0,1,0,1.
- Fixed build, req0 valid continuously, req1 valid: port 1 is granted after exactly STARVE_LIMIT=15 wait cycles, then the counter clears.
- Port 1 locked 3-write sequence (addr 0x1F0..0x1F2, we=4'hF) while req0 is valid: ready0 stays 0 until the cycle after the third write (lock=0), then port 0 is granted.
- Port 0 byte write we=4'b0010 data 0x0000AB00 to 0x005, then read 0x005: only byte 1 changes, rvalid0 one cycle after the read accept.
- Reset asserted during OWN1 with a read in flight: rvalid1 stays 0, and after release state is IDLE and req0 is granted immediately.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants for ram_arbiter: FSM state encoding, port indices and default starve limit.
package arb_pkg;

    localparam int unsigned STATE_W = 2;
    typedef logic [STATE_W-1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_OWN0 = 2'd1;
    localparam arb_state_t ST_OWN1 = 2'd2;

    localparam int unsigned PORT0 = 0;
    localparam int unsigned PORT1 = 1;

    localparam int unsigned STARVE_LIMIT_DEF = 15;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter for the fixed-priority arbiter; flags when port 1 has waited LIMIT cycles.
module starve_counter
    import arb_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_limit_q, at_limit_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        at_limit_d = (cnt_d == CNT_W'(LIMIT));
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q      <= '0;
            at_limit_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign at_limit_o = at_limit_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single synchronous RAM port with lockable ownership.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise fixed priority with port-1 starvation guard.
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WE_WIDTH     = 4,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  req0_valid_i,
    input  logic                  req0_lock_i,
    input  logic [WE_WIDTH-1:0]   req0_we_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,
    output logic                  req0_ready_o,
    output logic                  req0_rvalid_o,
    output logic [DATA_WIDTH-1:0] req0_rdata_o,
    input  logic                  req1_valid_i,
    input  logic                  req1_lock_i,
    input  logic [WE_WIDTH-1:0]   req1_we_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,
    output logic                  req1_ready_o,
    output logic                  req1_rvalid_o,
    output logic [DATA_WIDTH-1:0] req1_rdata_o,
    output logic [WE_WIDTH-1:0]   ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    arb_state_t state_q, state_d;
    logic [1:0] valid_c, lock_c, gnt_c;
    logic       tie_to1_c;
    logic       rvalid0_q, rvalid1_q;

    assign valid_c = {req1_valid_i, req0_valid_i};
    assign lock_c  = {req1_lock_i, req0_lock_i};

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q;  // port granted most recently

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_q <= 1'(PORT1);
        end else if (gnt_c[PORT0]) begin
            rr_q <= 1'(PORT0);
        end else if (gnt_c[PORT1]) begin
            rr_q <= 1'(PORT1);
        end
    end

    assign tie_to1_c = (rr_q == 1'(PORT0));
`else
    logic starve_max;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .inc_i      (valid_c[PORT1] & ~gnt_c[PORT1]),
        .clr_i      (gnt_c[PORT1]),
        .at_limit_o (starve_max)
    );

    assign tie_to1_c = starve_max;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner releases on an unlocked accept or when it goes quiet without lock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_c[PORT0] && lock_c[PORT0]) begin
                    state_d = ST_OWN0;
                end else if (gnt_c[PORT1] && lock_c[PORT1]) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!lock_c[PORT0] && (gnt_c[PORT0] || !valid_c[PORT0])) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!lock_c[PORT1] && (gnt_c[PORT1] || !valid_c[PORT1])) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant selection and RAM request mux; nothing is granted while reset is held.
    always_comb begin
        gnt_c       = '0;
        ram_we_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (reset_ni) begin
            case (state_q)
                ST_OWN0: gnt_c[PORT0] = valid_c[PORT0];
                ST_OWN1: gnt_c[PORT1] = valid_c[PORT1];
                default: begin
                    if (&valid_c) begin
                        if (tie_to1_c) begin
                            gnt_c[PORT1] = 1'b1;
                        end else begin
                            gnt_c[PORT0] = 1'b1;
                        end
                    end else begin
                        gnt_c = valid_c;
                    end
                end
            endcase
        end
        if (gnt_c[PORT0]) begin
            ram_we_o    = req0_we_i;
            ram_addr_o  = req0_addr_i;
            ram_wdata_o = req0_wdata_i;
        end else if (gnt_c[PORT1]) begin
            ram_we_o    = req1_we_i;
            ram_addr_o  = req1_addr_i;
            ram_wdata_o = req1_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt_c[PORT0] && (req0_we_i == '0);
            rvalid1_q <= gnt_c[PORT1] && (req1_we_i == '0);
        end
    end

    assign req0_ready_o  = gnt_c[PORT0];
    assign req1_ready_o  = gnt_c[PORT1];
    assign req0_rvalid_o = rvalid0_q;
    assign req1_rvalid_o = rvalid1_q;
    assign req0_rdata_o  = ram_rdata_i;
    assign req1_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, per-cycle reference model and directed scenarios.
module tb_ram_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 4;
    localparam int STARVE_LIMIT = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v0, l0, v1, l1;
    logic [WW-1:0] we0, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          rdy0, rdy1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    logic [WW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem    [512];
    logic [DW-1:0] shadow [512];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int            m_own;
    int            m_starve;
    int            m_last;
    bit            m_rv0, m_rv1;
    logic [DW-1:0] m_rd0, m_rd1;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .req0_valid_i  (v0),
        .req0_lock_i   (l0),
        .req0_we_i     (we0),
        .req0_addr_i   (a0),
        .req0_wdata_i  (d0),
        .req0_ready_o  (rdy0),
        .req0_rvalid_o (rv0),
        .req0_rdata_o  (rd0),
        .req1_valid_i  (v1),
        .req1_lock_i   (l1),
        .req1_we_i     (we1),
        .req1_addr_i   (a1),
        .req1_wdata_i  (d1),
        .req1_ready_o  (rdy1),
        .req1_rvalid_o (rv1),
        .req1_rdata_o  (rd1),
        .ram_we_o      (ram_we),
        .ram_addr_o    (ram_addr),
        .ram_wdata_o   (ram_wdata),
        .ram_rdata_i   (ram_rdata)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                            input logic [WW-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < int'(WW); b++) begin
            if (we[b]) r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // synchronous RAM with byte enables, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we != '0) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_we);
        ram_rdata <= mem[ram_addr];
    end

    // reference model: checks every cycle, then advances to the state after the next edge
    always @(negedge clk) begin
        int            g;
        logic [WW-1:0] ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (!rst_n) begin
            m_own = -1; m_starve = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0;
            chk("rst_ready0", 64'(rdy0), 64'(0));
            chk("rst_ready1", 64'(rdy1), 64'(0));
            chk("rst_ram_we", 64'(ram_we), 64'(0));
            chk("rst_rvalid0", 64'(rv0), 64'(0));
            chk("rst_rvalid1", 64'(rv1), 64'(0));
        end else begin
            g = -1;
            if (m_own == 0) g = v0 ? 0 : -1;
            else if (m_own == 1) g = v1 ? 1 : -1;
            else if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
                g = (m_last == 0) ? 1 : 0;
`else
                g = (m_starve >= STARVE_LIMIT) ? 1 : 0;
`endif
            end else if (v0) g = 0;
            else if (v1) g = 1;

            ewe = '0; ea = '0; ed = '0;
            if (g == 0) begin ewe = we0; ea = a0; ed = d0; end
            if (g == 1) begin ewe = we1; ea = a1; ed = d1; end

            chk("m_ready0", 64'(rdy0), 64'(g == 0));
            chk("m_ready1", 64'(rdy1), 64'(g == 1));
            chk("m_ram_we", 64'(ram_we), 64'(ewe));
            chk("m_ram_addr", 64'(ram_addr), 64'(ea));
            chk("m_ram_wdata", 64'(ram_wdata), 64'(ed));
            chk("m_rvalid0", 64'(rv0), 64'(m_rv0));
            chk("m_rvalid1", 64'(rv1), 64'(m_rv1));
            if (m_rv0) chk("m_rdata0", 64'(rd0), 64'(m_rd0));
            if (m_rv1) chk("m_rdata1", 64'(rd1), 64'(m_rd1));

            if (g >= 0 && ewe != '0) shadow[ea] = merge(shadow[ea], ed, ewe);
            m_rv0 = (g == 0) && (we0 == '0);
            m_rv1 = (g == 1) && (we1 == '0);
            m_rd0 = shadow[a0];
            m_rd1 = shadow[a1];
            if (g == 1) m_starve = 0;
            else if (v1 && m_starve < STARVE_LIMIT) m_starve++;
            if (g >= 0) m_last = g;
            if (m_own == -1) begin
                if (g == 0 && l0) m_own = 0;
                else if (g == 1 && l1) m_own = 1;
            end else if (m_own == 0) begin
                if (!l0 && (g == 0 || !v0)) m_own = -1;
            end else begin
                if (!l1 && (g == 1 || !v1)) m_own = -1;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v0 = 0; l0 = 0; we0 = '0; a0 = '0; d0 = '0;
        v1 = 0; l1 = 0; we1 = '0; a1 = '0; d1 = '0;
    endtask

    task automatic do_reset();
        next();
        rst_n = 0;
        idle();
        next();
        rst_n = 1;
    endtask

    initial begin
        int first;
        for (int i = 0; i < 512; i++) begin
            mem[i]    = 32'h5A5A_0000 ^ DW'(i * 7);
            shadow[i] = 32'h5A5A_0000 ^ DW'(i * 7);
        end
        mem[9'h010] = 32'hDEAD_BEEF; shadow[9'h010] = 32'hDEAD_BEEF;
        mem[9'h005] = 32'h1122_3344; shadow[9'h005] = 32'h1122_3344;
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ready0", 64'(rdy0), 64'(0));

        // read after reset release
        next();
        rst_n = 1; v0 = 1; a0 = 9'h010;
        @(negedge clk);
        chk("rd_ready0", 64'(rdy0), 64'(1));
        chk("rd_addr", 64'(ram_addr), 64'h010);
        next();
        v0 = 0;
        @(negedge clk);
        chk("rd_rvalid0", 64'(rv0), 64'(1));
        chk("rd_rdata0", 64'(rd0), 64'hDEAD_BEEF);
        next();
        @(negedge clk);
        chk("rd_rvalid0_once", 64'(rv0), 64'(0));

        // tie from idle, no locks
        do_reset();
        v0 = 1; a0 = 9'h010; v1 = 1; a1 = 9'h005;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            chk("tie_ready0", 64'(rdy0), 64'(k % 2 == 0));
            chk("tie_ready1", 64'(rdy1), 64'(k % 2 == 1));
`else
            chk("tie_ready0", 64'(rdy0), 64'(1));
            chk("tie_ready1", 64'(rdy1), 64'(0));
`endif
            next();
        end
        idle();

`ifndef ARB_ROUND_ROBIN_EN
        // starvation guard
        do_reset();
        v0 = 1; a0 = 9'h020; v1 = 1; a1 = 9'h021;
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            @(negedge clk);
            if (rdy1) first = i;
            next();
        end
        chk("starve_wait", 64'(first), 64'(15));
        @(negedge clk);
        chk("starve_clr_ready0", 64'(rdy0), 64'(1));
        chk("starve_clr_ready1", 64'(rdy1), 64'(0));
        next();
        idle();
`endif

        // port 1 locked write burst while port 0 waits
        do_reset();
        v1 = 1; l1 = 1; we1 = 4'hF; a1 = 9'h1F0; d1 = 32'hC0DE_01F0;
        @(negedge clk);
        chk("lk_ready1_a", 64'(rdy1), 64'(1));
        next();
        v0 = 1; a0 = 9'h005; a1 = 9'h1F1; d1 = 32'hC0DE_01F1;
        @(negedge clk);
        chk("lk_ready0_b", 64'(rdy0), 64'(0));
        chk("lk_ready1_b", 64'(rdy1), 64'(1));
        next();
        a1 = 9'h1F2; d1 = 32'hC0DE_01F2; l1 = 0;
        @(negedge clk);
        chk("lk_ready0_c", 64'(rdy0), 64'(0));
        chk("lk_ready1_c", 64'(rdy1), 64'(1));
        next();
        v1 = 0; l1 = 0; we1 = '0;
        @(negedge clk);
        chk("lk_ready0_d", 64'(rdy0), 64'(1));
        next();
        a0 = 9'h1F1;
        next();
        v0 = 0;
        @(negedge clk);
        chk("lk_readback", 64'(rd0), 64'hC0DE_01F1);
        next();

        // byte write then read back
        v0 = 1; we0 = 4'b0010; a0 = 9'h005; d0 = 32'h0000_AB00;
        @(negedge clk);
        chk("bw_ram_we", 64'(ram_we), 64'h2);
        next();
        we0 = '0;
        @(negedge clk);
        chk("bw_no_rvalid", 64'(rv0), 64'(0));
        next();
        v0 = 0;
        @(negedge clk);
        chk("bw_rvalid0", 64'(rv0), 64'(1));
        chk("bw_rdata0", 64'(rd0), 64'h1122_AB44);
        next();

        // reset during OWN1 with a read in flight
        do_reset();
        v1 = 1; l1 = 1; a1 = 9'h1F0;
        @(negedge clk);
        chk("rl_ready1", 64'(rdy1), 64'(1));
        #2 rst_n = 0;
        @(negedge clk);
        chk("rl_rvalid1", 64'(rv1), 64'(0));
        chk("rl_ready1_rst", 64'(rdy1), 64'(0));
        next();
        rst_n = 1; v0 = 1; a0 = 9'h010;
        @(negedge clk);
        chk("rl_ready0", 64'(rdy0), 64'(1));
        chk("rl_ready1_idle", 64'(rdy1), 64'(0));
        next();
        idle();
        @(negedge clk);
        chk("rl_rdata0", 64'(rd0), 64'hDEAD_BEEF);
        next();
        next();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
